// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, ALU codes,
// control-bus bit positions, state encoding and the opcode-to-ALU map.
package cpu_ctrl_pkg;

   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_ROR  = 5'd7;
   localparam logic [4:0] OP_ROL  = 5'd8;
   localparam logic [4:0] OP_SHR  = 5'd9;
   localparam logic [4:0] OP_SHRA = 5'd10;
   localparam logic [4:0] OP_SHL  = 5'd11;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;
   localparam logic [4:0] OP_NOP  = 5'd26;
   localparam logic [4:0] OP_HALT = 5'd27;

   localparam logic [15:0] ALU_INCPC = 16'd0;
   localparam logic [15:0] ALU_ADD   = 16'd1;
   localparam logic [15:0] ALU_SUB   = 16'd2;
   localparam logic [15:0] ALU_AND   = 16'd3;
   localparam logic [15:0] ALU_OR    = 16'd4;
   localparam logic [15:0] ALU_ROR   = 16'd5;
   localparam logic [15:0] ALU_ROL   = 16'd6;
   localparam logic [15:0] ALU_SHR   = 16'd7;
   localparam logic [15:0] ALU_SHRA  = 16'd8;
   localparam logic [15:0] ALU_SHL   = 16'd9;
   localparam logic [15:0] ALU_NEG   = 16'd10;
   localparam logic [15:0] ALU_NOT   = 16'd11;
   localparam logic [15:0] ALU_MUL   = 16'd14;
   localparam logic [15:0] ALU_DIV   = 16'd15;

   // Bit positions shared by Rin and Rout above the general registers
   localparam int BIT_HI    = 16;
   localparam int BIT_LO    = 17;
   localparam int BIT_ZHIGH = 18;
   localparam int BIT_ZLOW  = 19;
   localparam int BIT_PC    = 20;
   localparam int BIT_MDR   = 21;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_HALT = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOP    = 3'd0,
      CLS_RTYPE  = 3'd1,
      CLS_MULDIV = 3'd2,
      CLS_UNARY  = 3'd3,
      CLS_HALT   = 3'd4
   } op_class_t;

   function automatic logic [15:0] op_to_alu(input logic [4:0] op);
      logic [15:0] alu;
      case (op)
         OP_ADD:  alu = ALU_ADD;
         OP_SUB:  alu = ALU_SUB;
         OP_AND:  alu = ALU_AND;
         OP_OR:   alu = ALU_OR;
         OP_ROR:  alu = ALU_ROR;
         OP_ROL:  alu = ALU_ROL;
         OP_SHR:  alu = ALU_SHR;
         OP_SHRA: alu = ALU_SHRA;
         OP_SHL:  alu = ALU_SHL;
         OP_MUL:  alu = ALU_MUL;
         OP_DIV:  alu = ALU_DIV;
         OP_NEG:  alu = ALU_NEG;
         OP_NOT:  alu = ALU_NOT;
         default: alu = ALU_INCPC;
      endcase
      return alu;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: instruction class, ALU code and an
// undefined-opcode flag.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0]  i_opcode,
   output op_class_t   o_class,
   output logic [15:0] o_alu,
   output logic        o_illegal
);

   always_comb begin
      o_class   = CLS_NOP;
      o_alu     = op_to_alu(i_opcode);
      o_illegal = 1'b0;
      case (i_opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  o_class = CLS_RTYPE;
         OP_MUL, OP_DIV:                   o_class = CLS_MULDIV;
         OP_NEG, OP_NOT:                   o_class = CLS_UNARY;
         OP_NOP:                           o_class = CLS_NOP;
         OP_HALT:                          o_class = CLS_HALT;
         default:                          o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) and execute (T3-T6) sequencing that
// drives the DataPath control bus from the IR contents.
//
// state | meaning
// IDLE  | waiting for run
// T0    | PC to MAR, PC+1 into Zlow
// T1    | memory read, stall until mem_rdy; PC and MDR load on the ready cycle
// T2    | MDR into IR
// T3-T6 | execute phases, per instruction class
// HALT  | stopped; only clear leaves
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int NREG         = 16,
   parameter int MEM_WAIT_MAX = 15
)(
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        mem_rdy,
   output logic [31:0] Rin,
   output logic [31:0] Rout,
   output logic        IRin,
   output logic        MARin,
   output logic        RYin,
   output logic        MDRread,
   output logic        RBin,
   output logic        PCjump,
   output logic [15:0] ALUControl,
   output logic        halted,
   output logic        illegal,
   output logic        mem_timeout,
   output logic [3:0]  state_dbg
);

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CW-1:0] STALL_MAX  = CW'(MEM_WAIT_MAX);
   localparam logic [CW-1:0] STALL_LAST = CW'(MEM_WAIT_MAX - 1);

   state_t          r_state, w_next;
   logic [CW-1:0]   r_stall, w_stall_next;
   logic            r_illegal;
   op_class_t       w_cls;
   logic [15:0]     w_alu;
   logic            w_dec_illegal;
   logic [31:0]     w_sel_ra, w_sel_rb, w_sel_rc;
   state_t          w_end;
   logic            w_ir_unused;

   function automatic logic [31:0] reg_sel(input logic [3:0] idx);
      return 32'd1 << (int'(idx) % NREG);
   endfunction

   assign w_sel_ra    = reg_sel(ir[26:23]);
   assign w_sel_rb    = reg_sel(ir[22:19]);
   assign w_sel_rc    = reg_sel(ir[18:15]);
   assign w_ir_unused = ^ir[14:0];
   assign w_end       = run ? S_T0 : S_IDLE;

   ctrl_decode u_decode (
      .i_opcode  (ir[31:27]),
      .o_class   (w_cls),
      .o_alu     (w_alu),
      .o_illegal (w_dec_illegal)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state   <= S_IDLE;
         r_stall   <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         r_stall <= w_stall_next;
         if (r_state == S_T3 && w_dec_illegal)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_stall_next = r_stall;
      Rin          = '0;
      Rout         = '0;
      IRin         = 1'b0;
      MARin        = 1'b0;
      RYin         = 1'b0;
      MDRread      = 1'b0;
      RBin         = 1'b0;
      PCjump       = 1'b0;
      ALUControl   = ALU_INCPC;
      halted       = 1'b0;
      mem_timeout  = 1'b0;
      case (r_state)
         S_IDLE: if (run) w_next = S_T0;
         S_T0: begin
            Rout[BIT_PC]  = 1'b1;
            MARin         = 1'b1;
            Rin[BIT_ZLOW] = 1'b1;
            ALUControl    = ALU_INCPC;
            w_next        = S_T1;
         end
         S_T1: begin
            MDRread = 1'b1;
            if (mem_rdy) begin
               Rout[BIT_ZLOW] = 1'b1;
               Rin[BIT_PC]    = 1'b1;
               Rin[BIT_MDR]   = 1'b1;
               w_stall_next   = '0;
               w_next         = S_T2;
            end else begin
               // saturate so the timeout pulses once per stalled fetch
               if (r_stall != STALL_MAX)
                  w_stall_next = r_stall + 1'b1;
               mem_timeout = (r_stall == STALL_LAST);
            end
         end
         S_T2: begin
            Rout[BIT_MDR] = 1'b1;
            IRin          = 1'b1;
            w_next        = S_T3;
         end
         S_T3: begin
            case (w_cls)
               CLS_RTYPE:  begin Rout = w_sel_rb; RYin = 1'b1; w_next = S_T4; end
               CLS_MULDIV: begin Rout = w_sel_ra; RYin = 1'b1; w_next = S_T4; end
               CLS_UNARY: begin
                  Rout          = w_sel_rb;
                  ALUControl    = w_alu;
                  Rin[BIT_ZLOW] = 1'b1;
                  w_next        = S_T4;
               end
               CLS_HALT:   w_next = S_HALT;
               default:    w_next = w_end;
            endcase
         end
         S_T4: begin
            case (w_cls)
               CLS_RTYPE: begin
                  Rout          = w_sel_rc;
                  ALUControl    = w_alu;
                  Rin[BIT_ZLOW] = 1'b1;
                  w_next        = S_T5;
               end
               CLS_MULDIV: begin
                  Rout           = w_sel_rb;
                  ALUControl     = w_alu;
                  Rin[BIT_ZLOW]  = 1'b1;
                  Rin[BIT_ZHIGH] = 1'b1;
                  w_next         = S_T5;
               end
               CLS_UNARY: begin
                  Rout[BIT_ZLOW] = 1'b1;
                  Rin            = w_sel_ra;
                  w_next         = w_end;
               end
               default: w_next = w_end;
            endcase
         end
         S_T5: begin
            case (w_cls)
               CLS_RTYPE: begin
                  Rout[BIT_ZLOW] = 1'b1;
                  Rin            = w_sel_ra;
                  w_next         = w_end;
               end
               CLS_MULDIV: begin
                  Rout[BIT_ZLOW] = 1'b1;
                  Rin[BIT_LO]    = 1'b1;
                  w_next         = S_T6;
               end
               default: w_next = w_end;
            endcase
         end
         S_T6: begin
            Rout[BIT_ZHIGH] = 1'b1;
            Rin[BIT_HI]     = 1'b1;
            w_next          = w_end;
         end
         S_HALT:  halted = 1'b1;
         default: w_next = S_IDLE;
      endcase
      // clear silences the bus in the same cycle, before the register reset lands
      if (clear) begin
         Rin         = '0;
         Rout        = '0;
         IRin        = 1'b0;
         MARin       = 1'b0;
         RYin        = 1'b0;
         MDRread     = 1'b0;
         ALUControl  = ALU_INCPC;
         halted      = 1'b0;
         mem_timeout = 1'b0;
      end
   end

   assign illegal   = r_illegal & ~clear;
   assign state_dbg = clear ? S_IDLE : r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed and random instructions compared
// cycle by cycle against a per-instruction expected control schedule.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        clear, run, mem_rdy;
   logic [31:0] ir;
   logic [31:0] Rin, Rout;
   logic        IRin, MARin, RYin, MDRread, RBin, PCjump;
   logic [15:0] ALUControl;
   logic        halted, illegal, mem_timeout;
   logic [3:0]  state_dbg;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [31:0] rin;
      logic [31:0] rout;
      logic        irin, marin, ryin, mdrread, rbin, pcjump;
      logic [15:0] alu;
      logic        halted, ill, mto;
      logic [3:0]  st;
   } exp_t;

   localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3,
                          ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7,
                          ST_HALT = 4'd8;

   logic        m_illegal = 1'b0;
   logic [31:0] cur_ir = 32'd0;

   control_sequencer dut (
      .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_rdy(mem_rdy),
      .Rin(Rin), .Rout(Rout), .IRin(IRin), .MARin(MARin), .RYin(RYin),
      .MDRread(MDRread), .RBin(RBin), .PCjump(PCjump), .ALUControl(ALUControl),
      .halted(halted), .illegal(illegal), .mem_timeout(mem_timeout),
      .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   task automatic step(input logic mr, input logic [31:0] irv, input exp_t e, input string tag);
      exp_t o;
      @(negedge clock);
      mem_rdy = mr;
      ir      = irv;
      #1;
      o.rin = Rin;       o.rout = Rout;
      o.irin = IRin;     o.marin = MARin;   o.ryin = RYin;
      o.mdrread = MDRread; o.rbin = RBin;   o.pcjump = PCjump;
      o.alu = ALUControl; o.halted = halted; o.ill = illegal;
      o.mto = mem_timeout; o.st = state_dbg;
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (state %0d vs %0d)", tag, o, e, o.st, e.st);
      end
   endtask

   function automatic exp_t blank(input logic [3:0] st);
      exp_t e = '0;
      e.st  = st;
      e.ill = m_illegal;
      return e;
   endfunction

   // Expected schedule built from the instruction's class: ALU codes follow
   // from the opcode by fixed offsets within each opcode group.
   task automatic do_instr(input logic [31:0] instr, input int delay, input logic run_end);
      exp_t e;
      int op, ra, rb, rc;
      op = int'(instr[31:27]);
      ra = int'(instr[26:23]);
      rb = int'(instr[22:19]);
      rc = int'(instr[18:15]);

      e = blank(ST_T0); e.rout[20] = 1; e.marin = 1; e.rin[19] = 1;
      step(0, cur_ir, e, "T0");
      for (int k = 1; k <= delay; k++) begin
         e = blank(ST_T1); e.mdrread = 1; e.mto = (k == 15);
         step(0, cur_ir, e, "T1_stall");
      end
      e = blank(ST_T1); e.mdrread = 1; e.rout[19] = 1; e.rin[20] = 1; e.rin[21] = 1;
      step(1, cur_ir, e, "T1_ready");
      e = blank(ST_T2); e.rout[21] = 1; e.irin = 1;
      step(0, cur_ir, e, "T2");
      run    = run_end;
      cur_ir = instr;

      if (op >= 3 && op <= 11) begin
         e = blank(ST_T3); e.rout[rb] = 1; e.ryin = 1;               step(0, instr, e, "R_T3");
         e = blank(ST_T4); e.rout[rc] = 1; e.alu = 16'(op - 2); e.rin[19] = 1;
         step(0, instr, e, "R_T4");
         e = blank(ST_T5); e.rout[19] = 1; e.rin[ra] = 1;            step(0, instr, e, "R_T5");
      end else if (op == 15 || op == 16) begin
         e = blank(ST_T3); e.rout[ra] = 1; e.ryin = 1;               step(0, instr, e, "MD_T3");
         e = blank(ST_T4); e.rout[rb] = 1; e.alu = 16'(op - 1); e.rin[18] = 1; e.rin[19] = 1;
         step(0, instr, e, "MD_T4");
         e = blank(ST_T5); e.rout[19] = 1; e.rin[17] = 1;            step(0, instr, e, "MD_T5");
         e = blank(ST_T6); e.rout[18] = 1; e.rin[16] = 1;            step(0, instr, e, "MD_T6");
      end else if (op == 17 || op == 18) begin
         e = blank(ST_T3); e.rout[rb] = 1; e.alu = 16'(op - 7); e.rin[19] = 1;
         step(0, instr, e, "U_T3");
         e = blank(ST_T4); e.rout[19] = 1; e.rin[ra] = 1;            step(0, instr, e, "U_T4");
      end else begin
         e = blank(ST_T3);
         step(0, instr, e, "NOP_T3");
         if (op != 26 && op != 27) m_illegal = 1'b1;
      end
   endtask

   function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
      return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
   endfunction

   int ops[14] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18, 26};

   task automatic rand_instr(input logic run_end);
      do_instr(mk(ops[$urandom_range(0, 13)], $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15)),
               $urandom_range(0, 4), run_end);
   endtask

   initial begin
      exp_t e;
      clear = 1'b1; run = 1'b1; mem_rdy = 1'b0; ir = 32'd0;
      e = blank(ST_IDLE); step(0, 32'd0, e, "clear_0");
      e = blank(ST_IDLE); step(0, 32'd0, e, "clear_1");
      clear = 1'b0;

      do_instr(mk(15, 3, 1, 0), 3, 1'b1);
      do_instr(mk(3, 5, 2, 4), 0, 1'b1);
      repeat (8) rand_instr(1'b1);

      do_instr(mk(31, 2, 6, 9), 1, 1'b1);
      rand_instr(1'b1);
      do_instr(mk(9, 0, 7, 14), 2, 1'b1);

      // long stall then run dropped mid-instruction
      do_instr(mk(17, 12, 4, 0), 17, 1'b0);
      e = blank(ST_IDLE); step(0, cur_ir, e, "idle_0");
      e = blank(ST_IDLE); step(0, cur_ir, e, "idle_1");
      run = 1'b1;

      repeat (6) rand_instr(1'b1);
      do_instr(mk(18, 15, 3, 0), 0, 1'b1);
      do_instr(mk(26, 1, 1, 1), 1, 1'b1);

      do_instr(mk(27, 0, 0, 0), 2, 1'b1);
      for (int i = 0; i < 10; i++) begin
         e = blank(ST_HALT); e.halted = 1;
         step(0, cur_ir, e, "halt");
      end
      clear = 1'b1;
      e = blank(ST_IDLE); e.ill = 1'b0; step(0, cur_ir, e, "halt_clear");
      m_illegal = 1'b0;
      clear = 1'b0; run = 1'b0;
      e = blank(ST_IDLE); step(0, cur_ir, e, "post_clear_0");
      e = blank(ST_IDLE); step(0, cur_ir, e, "post_clear_1");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
